// File: rtl/cpu_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_ctrl_pkg
// Brief    : Shared encodings and types for the multi-cycle control sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package cpu_ctrl_pkg;

    localparam logic HIGH = 1'b1;
    localparam logic LOW  = 1'b0;

    localparam logic [1:0] R_Type = 2'b00;
    localparam logic [1:0] S_Type = 2'b01;
    localparam logic [1:0] I_Type = 2'b10;
    localparam logic [1:0] J_Type = 2'b11;

    localparam logic [4:0] AND  = 5'd0;
    localparam logic [4:0] ADD  = 5'd1;
    localparam logic [4:0] SUB  = 5'd2;
    localparam logic [4:0] CMP  = 5'd3;
    localparam logic [4:0] ANDI = 5'd4;
    localparam logic [4:0] ADDI = 5'd5;
    localparam logic [4:0] LW   = 5'd6;
    localparam logic [4:0] SW   = 5'd7;
    localparam logic [4:0] BEQ  = 5'd8;
    localparam logic [4:0] BNE  = 5'd9;
    localparam logic [4:0] J    = 5'd10;
    localparam logic [4:0] JAL  = 5'd11;
    localparam logic [4:0] SLL  = 5'd12;
    localparam logic [4:0] SLR  = 5'd13;
    localparam logic [4:0] SLLV = 5'd14;
    localparam logic [4:0] SLRV = 5'd15;

    localparam logic [1:0] PC_Src_Dft = 2'b00;
    localparam logic [1:0] PC_Src_BTA = 2'b01;
    localparam logic [1:0] PC_Src_Jmp = 2'b10;
    localparam logic [1:0] PC_Src_Ra  = 2'b11;

    localparam logic [1:0] ALU_Src_Reg = 2'b00;
    localparam logic [1:0] ALU_Src_UIm = 2'b01;
    localparam logic [1:0] ALU_Src_SIm = 2'b10;
    localparam logic [1:0] ALU_Src_SAi = 2'b11;

    localparam logic [2:0] ALU_Add = 3'd0;
    localparam logic [2:0] ALU_Sub = 3'd1;
    localparam logic [2:0] ALU_And = 3'd2;
    localparam logic [2:0] ALU_SLL = 3'd3;
    localparam logic [2:0] ALU_SLR = 3'd4;

    typedef enum logic [2:0] {
        INIT = 3'd0,
        FTCH = 3'd1,
        DCDE = 3'd2,
        EXEC = 3'd3,
        MEM  = 3'd4,
        WRB  = 3'd5,
        ERR  = 3'd6
    } stage_t;

    typedef struct packed {
        logic [2:0] alu_op;
        logic [1:0] pc_src;
        logic [1:0] alu_src;
        logic       rb_src;
        logic       wb_sel;
        logic       rf_we;
        logic       mem_we;
        logic       mem_re;
        logic       en_fetch;
        logic       en_decode;
        logic       en_execute;
        logic       instr_done;
        logic       error;
    } ctrl_out_t;

endpackage
`default_nettype wire

// File: rtl/ctrl_decode.sv
`default_nettype none
// ============================================================================
// Module   : ctrl_decode
// Brief    : Combinational instruction decode: ALU op/src, PC source, next stage.
// Revision : 1.0 - initial release
// ============================================================================
module ctrl_decode
    import cpu_ctrl_pkg::*;
#(
    parameter int FUNC_W = 5
) (
    input  logic [1:0]        i_instr_type,
    input  logic [FUNC_W-1:0] i_func,
    input  logic              i_stop,
    input  logic              i_flag_zero,
    output logic [2:0]        o_alu_op,
    output logic [1:0]        o_alu_src,
    output stage_t            o_exec_next,
    output logic [1:0]        o_pc_src,
    output logic              o_is_jump,
    output logic              o_is_lw,
    output logic              o_is_sw,
    output logic              o_is_jal,
    output logic              o_is_itype
);

    logic w_and, w_sub, w_cmp, w_andi, w_lw, w_sw, w_beq, w_bne;
    logic w_j, w_jal, w_sll, w_slr, w_sllv, w_slrv;

    assign w_and  = (i_func == FUNC_W'(AND));
    assign w_sub  = (i_func == FUNC_W'(SUB));
    assign w_cmp  = (i_func == FUNC_W'(CMP));
    assign w_andi = (i_func == FUNC_W'(ANDI));
    assign w_lw   = (i_func == FUNC_W'(LW));
    assign w_sw   = (i_func == FUNC_W'(SW));
    assign w_beq  = (i_func == FUNC_W'(BEQ));
    assign w_bne  = (i_func == FUNC_W'(BNE));
    assign w_j    = (i_func == FUNC_W'(J));
    assign w_jal  = (i_func == FUNC_W'(JAL));
    assign w_sll  = (i_func == FUNC_W'(SLL));
    assign w_slr  = (i_func == FUNC_W'(SLR));
    assign w_sllv = (i_func == FUNC_W'(SLLV));
    assign w_slrv = (i_func == FUNC_W'(SLRV));

    assign o_is_jump  = (i_instr_type == J_Type) && w_j;
    assign o_is_lw    = w_lw;
    assign o_is_sw    = w_sw;
    assign o_is_jal   = w_jal;
    assign o_is_itype = (i_instr_type == I_Type);

    always_comb begin
        o_alu_op    = ALU_Add;
        o_alu_src   = ALU_Src_Reg;
        o_exec_next = WRB;
        o_pc_src    = PC_Src_Dft;

        if (w_sll || w_sllv)                        o_alu_op = ALU_SLL;
        else if (w_slr || w_slrv)                   o_alu_op = ALU_SLR;
        else if (w_and || w_andi)                   o_alu_op = ALU_And;
        else if (w_sub || w_cmp || w_beq || w_bne)  o_alu_op = ALU_Sub;

        if ((i_instr_type == S_Type) && (w_sll || w_slr)) o_alu_src = ALU_Src_SAi;
        else if (i_instr_type == I_Type)                  o_alu_src = w_andi ? ALU_Src_UIm : ALU_Src_SIm;

        if (w_lw || w_sw || w_jal)          o_exec_next = MEM;
        else if (w_beq || w_bne || w_cmp)   o_exec_next = FTCH;

        // Branch resolution uses the flags left by the previous instruction.
        if (i_stop)                                                o_pc_src = PC_Src_Ra;
        else if (i_instr_type == J_Type)                           o_pc_src = PC_Src_Jmp;
        else if ((i_instr_type == I_Type) && w_beq && i_flag_zero)  o_pc_src = PC_Src_BTA;
        else if ((i_instr_type == I_Type) && w_bne && !i_flag_zero) o_pc_src = PC_Src_BTA;
    end

endmodule
`default_nettype wire

// File: rtl/multicycle_control_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_control_sequencer
// Brief    : Multi-cycle FTCH/DCDE/EXEC/MEM/WRB control FSM with ready waits,
//            stall, timeout error and optional counters (CTRL_PERF_COUNTERS_EN).
// Revision : 1.0 - initial release
// ============================================================================
module multicycle_control_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int FUNC_W      = 5,
    parameter int ALU_OP_W    = 3,
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 32
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [1:0]          InstructionType,
    input  logic [FUNC_W-1:0]   FunctionCode,
    input  logic                StopBit,
    input  logic                flag_zero,
    input  logic                stall,
    input  logic                imem_ready,
    input  logic                dmem_ready,
    output logic [ALU_OP_W-1:0] sig_alu_op,
    output logic [1:0]          sig_pc_src,
    output logic [1:0]          sig_alu_src,
    output logic                sig_rb_src,
    output logic                sig_write_back_data_select,
    output logic                sig_rf_enable_write,
    output logic                sig_enable_data_memory_write,
    output logic                sig_enable_data_memory_read,
    output logic                en_instruction_fetch,
    output logic                en_instruction_decode,
    output logic                en_execute,
    output logic                instr_done,
    output logic                sig_error
`ifdef CTRL_PERF_COUNTERS_EN
    ,
    output logic [CNT_W-1:0]    perf_retired,
    output logic [CNT_W-1:0]    perf_stall
`endif
);

    localparam int c_WAIT_W = $clog2(MEM_TIMEOUT + 1);

    if ((MEM_TIMEOUT < 1) || (CNT_W < 1)) begin : g_param_check
        $error("multicycle_control_sequencer: MEM_TIMEOUT and CNT_W must be >= 1");
    end

    stage_t                r_state, w_next;
    ctrl_out_t             r_out, w_out;
    logic [c_WAIT_W-1:0]   r_wait, w_wait;
    logic                  w_waiting;

    logic [2:0] w_alu_op;
    logic [1:0] w_alu_src, w_pc_src;
    stage_t     w_exec_next;
    logic       w_is_jump, w_is_lw, w_is_sw, w_is_jal, w_is_itype;

    ctrl_decode #(.FUNC_W(FUNC_W)) u_decode (
        .i_instr_type (InstructionType),
        .i_func       (FunctionCode),
        .i_stop       (StopBit),
        .i_flag_zero  (flag_zero),
        .o_alu_op     (w_alu_op),
        .o_alu_src    (w_alu_src),
        .o_exec_next  (w_exec_next),
        .o_pc_src     (w_pc_src),
        .o_is_jump    (w_is_jump),
        .o_is_lw      (w_is_lw),
        .o_is_sw      (w_is_sw),
        .o_is_jal     (w_is_jal),
        .o_is_itype   (w_is_itype)
    );

    always_comb begin
        w_next           = r_state;
        w_out            = r_out;
        w_out.instr_done = LOW;
        w_wait           = r_wait;
        w_waiting        = LOW;

        if (!stall) begin
            case (r_state)
                INIT: w_next = FTCH;
                FTCH: if (imem_ready) w_next = DCDE; else w_waiting = HIGH;
                DCDE: w_next = w_is_jump ? FTCH : EXEC;
                EXEC: w_next = w_exec_next;
                MEM: begin
                    if (dmem_ready || w_is_jal) w_next = w_is_lw ? WRB : FTCH;
                    else                        w_waiting = HIGH;
                end
                WRB:     w_next = FTCH;
                ERR:     w_next = ERR;
                default: w_next = INIT;
            endcase

            // Ready arriving on the last allowed wait cycle still completes.
            if (w_waiting) begin
                if (r_wait == c_WAIT_W'(MEM_TIMEOUT - 1)) w_next = ERR;
                else                                      w_wait = r_wait + 1'b1;
            end

            // Outputs change only on state entry, so waits hold them steady.
            if (w_next != r_state) begin
                case (w_next)
                    FTCH: begin
                        w_out.pc_src     = w_pc_src;
                        w_out.en_fetch   = HIGH;
                        w_out.en_decode  = LOW;
                        w_out.en_execute = LOW;
                        w_out.rf_we      = LOW;
                        w_out.mem_we     = LOW;
                        w_out.mem_re     = LOW;
                        w_out.instr_done = (r_state != INIT);
                        w_wait           = '0;
                    end
                    DCDE: begin
                        w_out.en_fetch  = LOW;
                        w_out.en_decode = HIGH;
                        w_out.rb_src    = w_is_itype;
                    end
                    EXEC: begin
                        w_out.en_decode  = LOW;
                        w_out.en_execute = HIGH;
                        w_out.alu_op     = w_alu_op;
                        w_out.alu_src    = w_alu_src;
                    end
                    MEM: begin
                        w_out.en_execute = LOW;
                        w_out.mem_we     = w_is_sw;
                        w_out.mem_re     = w_is_lw;
                        w_wait           = '0;
                    end
                    WRB: begin
                        w_out.en_execute = LOW;
                        w_out.mem_we     = LOW;
                        w_out.mem_re     = LOW;
                        w_out.rf_we      = HIGH;
                        w_out.wb_sel     = w_is_lw;
                    end
                    ERR: begin
                        w_out.en_fetch   = LOW;
                        w_out.en_decode  = LOW;
                        w_out.en_execute = LOW;
                        w_out.rf_we      = LOW;
                        w_out.mem_we     = LOW;
                        w_out.mem_re     = LOW;
                        w_out.error      = HIGH;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= INIT;
            r_out   <= '0;
            r_wait  <= '0;
        end else begin
            r_state <= w_next;
            r_out   <= w_out;
            r_wait  <= w_wait;
        end
    end

    assign sig_alu_op                   = ALU_OP_W'(r_out.alu_op);
    assign sig_pc_src                   = r_out.pc_src;
    assign sig_alu_src                  = r_out.alu_src;
    assign sig_rb_src                   = r_out.rb_src;
    assign sig_write_back_data_select   = r_out.wb_sel;
    assign sig_rf_enable_write          = r_out.rf_we;
    assign sig_enable_data_memory_write = r_out.mem_we;
    assign sig_enable_data_memory_read  = r_out.mem_re;
    assign en_instruction_fetch         = r_out.en_fetch;
    assign en_instruction_decode        = r_out.en_decode;
    assign en_execute                   = r_out.en_execute;
    assign instr_done                   = r_out.instr_done;
    assign sig_error                    = r_out.error;

`ifdef CTRL_PERF_COUNTERS_EN
    logic [CNT_W-1:0] r_perf_retired, r_perf_stall;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_perf_retired <= '0;
            r_perf_stall   <= '0;
        end else begin
            if (w_out.instr_done)    r_perf_retired <= r_perf_retired + 1'b1;
            if (stall || w_waiting)  r_perf_stall   <= r_perf_stall + 1'b1;
        end
    end

    assign perf_retired = r_perf_retired;
    assign perf_stall   = r_perf_stall;
`endif

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_multicycle_control_sequencer
// Brief    : Directed self-checking bench for multicycle_control_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multicycle_control_sequencer;
    import cpu_ctrl_pkg::*;

    logic       clock = 1'b0;
    logic       reset;
    logic [1:0] InstructionType;
    logic [4:0] FunctionCode;
    logic       StopBit, flag_zero, stall, imem_ready, dmem_ready;
    logic [2:0] sig_alu_op;
    logic [1:0] sig_pc_src, sig_alu_src;
    logic       sig_rb_src, sig_write_back_data_select, sig_rf_enable_write;
    logic       sig_enable_data_memory_write, sig_enable_data_memory_read;
    logic       en_instruction_fetch, en_instruction_decode, en_execute;
    logic       instr_done, sig_error;
`ifdef CTRL_PERF_COUNTERS_EN
    logic [31:0] perf_retired, perf_stall;
`endif

    int n_vec = 0;
    int n_err = 0;

    multicycle_control_sequencer dut (
        .clock                        (clock),
        .reset                        (reset),
        .InstructionType              (InstructionType),
        .FunctionCode                 (FunctionCode),
        .StopBit                      (StopBit),
        .flag_zero                    (flag_zero),
        .stall                        (stall),
        .imem_ready                   (imem_ready),
        .dmem_ready                   (dmem_ready),
        .sig_alu_op                   (sig_alu_op),
        .sig_pc_src                   (sig_pc_src),
        .sig_alu_src                  (sig_alu_src),
        .sig_rb_src                   (sig_rb_src),
        .sig_write_back_data_select   (sig_write_back_data_select),
        .sig_rf_enable_write          (sig_rf_enable_write),
        .sig_enable_data_memory_write (sig_enable_data_memory_write),
        .sig_enable_data_memory_read  (sig_enable_data_memory_read),
        .en_instruction_fetch         (en_instruction_fetch),
        .en_instruction_decode        (en_instruction_decode),
        .en_execute                   (en_execute),
        .instr_done                   (instr_done),
        .sig_error                    (sig_error)
`ifdef CTRL_PERF_COUNTERS_EN
        ,
        .perf_retired                 (perf_retired),
        .perf_stall                   (perf_stall)
`endif
    );

    always #5 clock = ~clock;

    // {fetch, decode, execute, rf_we, mem_we, mem_re, wb_sel, rb_src, done, error}
    logic [9:0] w_ctl;
    assign w_ctl = {en_instruction_fetch, en_instruction_decode, en_execute,
                    sig_rf_enable_write, sig_enable_data_memory_write,
                    sig_enable_data_memory_read, sig_write_back_data_select,
                    sig_rb_src, instr_done, sig_error};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_ir(input logic [1:0] t, input logic [4:0] f);
        InstructionType = t;
        FunctionCode    = f;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; StopBit = 1'b0; flag_zero = 1'b0; stall = 1'b0;
        imem_ready = 1'b1; dmem_ready = 1'b1;
        set_ir(R_Type, ADD);
        tick(); tick();
        check("reset_ctl", 32'(w_ctl), 32'h000);
        check("reset_pc", 32'(sig_pc_src), 32'(PC_Src_Dft));
        check("reset_alusrc", 32'(sig_alu_src), 32'(ALU_Src_Reg));

        // ADD, zero-wait
        reset = 1'b0;
        tick(); check("add_ftch", 32'(w_ctl), 32'(10'b1000000000));
        tick(); check("add_dcde", 32'(w_ctl), 32'(10'b0100000000));
        tick(); check("add_exec", 32'(w_ctl), 32'(10'b0010000000));
        check("add_aluop", 32'(sig_alu_op), 32'(ALU_Add));
        tick(); check("add_wrb", 32'(w_ctl), 32'(10'b0001000000));
        tick(); check("add_done", 32'(w_ctl), 32'(10'b1000000010));

        // LW with three dmem wait cycles
        set_ir(I_Type, LW);
        tick(); check("lw_dcde", 32'(w_ctl), 32'(10'b0100000100));
        tick(); check("lw_exec", 32'(w_ctl), 32'(10'b0010000100));
        check("lw_alusrc", 32'(sig_alu_src), 32'(ALU_Src_SIm));
        dmem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick(); check("lw_mem", 32'(w_ctl), 32'(10'b0000010100));
            if (i == 3) dmem_ready = 1'b1;
        end
        tick(); check("lw_wrb", 32'(w_ctl), 32'(10'b0001001100));
        tick(); check("lw_done", 32'(w_ctl), 32'(10'b1000001110));

        // BEQ taken, then BNE not taken
        set_ir(I_Type, BEQ); flag_zero = 1'b1;
        tick(); tick(); check("beq_aluop", 32'(sig_alu_op), 32'(ALU_Sub));
        tick(); check("beq_done", 32'(w_ctl), 32'(10'b1000001110));
        check("beq_pc", 32'(sig_pc_src), 32'(PC_Src_BTA));
        set_ir(I_Type, BNE);
        tick(); tick(); tick(); check("bne_done", 32'(w_ctl), 32'(10'b1000001110));
        check("bne_pc", 32'(sig_pc_src), 32'(PC_Src_Dft));

        // J: two cycles
        set_ir(J_Type, J); flag_zero = 1'b0;
        tick(); check("j_dcde", 32'(w_ctl), 32'(10'b0100001000));
        tick(); check("j_done", 32'(w_ctl), 32'(10'b1000001010));
        check("j_pc", 32'(sig_pc_src), 32'(PC_Src_Jmp));

        // SW
        set_ir(I_Type, SW);
        tick(); tick(); tick(); check("sw_mem", 32'(w_ctl), 32'(10'b0000101100));
        tick(); check("sw_done", 32'(w_ctl), 32'(10'b1000001110));

        // JAL ignores dmem_ready
        set_ir(J_Type, JAL); dmem_ready = 1'b0;
        tick(); check("jal_dcde", 32'(w_ctl), 32'(10'b0100001000));
        tick(); tick(); check("jal_mem", 32'(w_ctl), 32'(10'b0000001000));
        tick(); check("jal_done", 32'(w_ctl), 32'(10'b1000001010));
        check("jal_pc", 32'(sig_pc_src), 32'(PC_Src_Jmp));
        dmem_ready = 1'b1;

        // SUB stalled five cycles in EXEC
        set_ir(R_Type, SUB);
        tick(); tick(); check("sub_exec", 32'(w_ctl), 32'(10'b0010001000));
        stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick(); check("sub_stall", 32'(w_ctl), 32'(10'b0010001000));
            check("sub_stall_op", 32'(sig_alu_op), 32'(ALU_Sub));
        end
        stall = 1'b0;
        tick(); check("sub_wrb", 32'(w_ctl), 32'(10'b0001000000));
        StopBit = 1'b1;
        tick(); check("sub_done", 32'(w_ctl), 32'(10'b1000000010));
        check("stop_pc", 32'(sig_pc_src), 32'(PC_Src_Ra));
        StopBit = 1'b0;

        // ready on the last allowed wait cycle completes normally
        set_ir(R_Type, ADD); imem_ready = 1'b0;
        for (int i = 0; i < 14; i++) tick();
        check("wait14_ftch", 32'(w_ctl), 32'(10'b1000000000));
        imem_ready = 1'b1;
        tick(); check("wait14_dcde", 32'(w_ctl), 32'(10'b0100000000));
        tick(); tick(); tick(); check("wait14_done", 32'(w_ctl), 32'(10'b1000000010));

        // timeout into ERR after fifteen waiting cycles
        imem_ready = 1'b0;
        for (int i = 0; i < 14; i++) tick();
        check("to_pre", 32'(w_ctl), 32'(10'b1000000000));
        tick(); check("to_err", 32'(w_ctl), 32'(10'b0000000001));
        imem_ready = 1'b1;
        tick(); tick(); check("err_sticky", 32'(w_ctl), 32'(10'b0000000001));
        reset = 1'b1;
        tick(); check("err_reset", 32'(w_ctl), 32'h000);
        reset = 1'b0;
        tick(); check("restart_ftch", 32'(w_ctl), 32'(10'b1000000000));

`ifdef CTRL_PERF_COUNTERS_EN
        reset = 1'b1; set_ir(J_Type, J);
        tick();
        check("perf_rst", perf_retired, 32'd0);
        reset = 1'b0;
        tick();
        for (int i = 0; i < 20; i++) tick();
        check("perf_retired", perf_retired, 32'd10);
        check("perf_stall", perf_stall, 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
